fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the 16-bit asynchronous FIFO. It shares the single write port (w_en, D_in, full) between N independent requesters in the write clock domain. Grants are packet-locked: a requester keeps the port from its first beat through its last beat, so packets are never interleaved in the FIFO. The block sits entirely in the w_clk domain, directly in front of the FIFO write interface.

---
 rtl/fifo_wr_arbiter_if.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-side signals for the round-robin write-port
// arbiter. The arbiter connects through the slave modport. The environment
// (requesters plus FIFO) connects through the master modport.
//
// Handshake: a beat from requester i transfers on a rising w_clk edge when
// req_valid[i] and req_ready[i] are both high in the cycle before that edge.
// Each requester holds req_data and req_last stable until that beat transfers.
// req_ready is one-hot or zero. fifo_w_en marks the same transfer toward the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]        req_valid;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_last;
    logic [N-1:0]        req_ready;
    logic                fifo_full;
    logic                fifo_w_en;
    logic [DATA_W-1:0]   fifo_d_in;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;
    logic [CNT_W-1:0]    word_cnt;
    logic                state_dbg;   // 1 while the arbiter FSM is in GRANT

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_w_en, fifo_d_in, grant_vld, grant_id, word_cnt, state_dbg
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_w_en, fifo_d_in, grant_vld, grant_id, word_cnt, state_dbg
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that shares one FIFO write port among N
// requesters in the write clock domain. A grant is held from a packet's first
// beat through its last beat. The arbiter always spends one IDLE cycle between packets.
module fifo_wr_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input logic              w_clk,
    input logic              wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   grant_id_q;
    logic              grant_vld_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              fire;
    logic [N-1:0]      ready_vec;
    logic [DATA_W-1:0] d_in;

    // Circular search for the first valid requester, starting just above the one served last.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= N; k++) begin
            if (!pick_found && bus.req_valid[(int'(last_id) + k) % N]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(last_id) + k) % N);
            end
        end
    end

    // Drive the write-port handshake from the current grant. A full FIFO blocks both ready and the write.
    always_comb begin
        ready_vec = '0;
        d_in      = '0;
        fire      = 1'b0;
        if (state == GRANT) begin
            d_in = bus.req_data[grant_id_q*DATA_W +: DATA_W];
            if (!bus.fifo_full) begin
                ready_vec[grant_id_q] = 1'b1;
                fire                  = bus.req_valid[grant_id_q];
            end
        end
    end

    // Arbitration FSM. The grant is locked until the beat marked last has transferred.
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            state       <= IDLE;
            last_id     <= ID_W'(N - 1);
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        grant_id_q  <= pick_id;
                        last_id     <= pick_id;
                        grant_vld_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (fire && bus.req_last[grant_id_q]) begin
                        state       <= IDLE;
                        grant_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Count accepted words. The counter wraps naturally at 2^CNT_W.
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            word_cnt_q <= '0;
        end else if (fire) begin
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.fifo_w_en = fire;
    assign bus.fifo_d_in = d_in;
    assign bus.grant_vld = grant_vld_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.state_dbg = (state == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. It runs directed packet scenarios followed by
// random per-cycle traffic. All checks are made against a packet-level
// reference model that predicts the arbiter's outputs. A second instance with
// a 4-bit counter sees identical inputs so that counter wrap can be checked.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 16;

    logic w_clk;
    logic wrst;

    fifo_wr_arbiter_if #(.N(N), .DATA_W(DW), .CNT_W(CW)) bus ();
    fifo_wr_arbiter_if #(.N(N), .DATA_W(DW), .CNT_W(4))  bus4 ();

    fifo_wr_arbiter #(.N(N), .DATA_W(DW), .CNT_W(CW)) u_dut (
        .w_clk (w_clk),
        .wrst  (wrst),
        .bus   (bus.slave)
    );

    fifo_wr_arbiter #(.N(N), .DATA_W(DW), .CNT_W(4)) u_dut4 (
        .w_clk (w_clk),
        .wrst  (wrst),
        .bus   (bus4.slave)
    );

    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_data  = bus.req_data;
    assign bus4.req_last  = bus.req_last;
    assign bus4.fifo_full = bus.fifo_full;

    // ---------------- clock / reset ----------------
    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    task automatic do_reset();
        wrst = 1'b1;
        repeat (2) @(posedge w_clk);
        #1 wrst = 1'b0;
    endtask

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model + scoreboard ----------------
    int          holder   = -1;     // requester owning the port, -1 when free
    int          last_srv = N - 1;  // requester served most recently
    int unsigned words    = 0;      // words accepted since reset
    int          cyc      = 0;
    logic        prev_gvld = 1'b0;
    logic [DW-1:0] exp_q[$];        // words the FIFO should receive
    int          glog[$];           // grant ids in the order they rise
    int          gcyc[$];           // cycle of each grant rise
    int          wcyc[$];           // cycle of each write

    always @(negedge w_clk) begin
        logic [N-1:0]  e_ready;
        logic          e_wen;
        logic [DW-1:0] e_d;
        int            idx;
        cyc++;
        e_ready = '0;
        e_wen   = 1'b0;
        e_d     = '0;
        idx     = 0;
        if (wrst) begin
            check("rst_grant_vld", bus.grant_vld, 0);
            check("rst_grant_id",  bus.grant_id,  0);
            check("rst_word_cnt",  bus.word_cnt,  0);
            check("rst_word_cnt4", bus4.word_cnt, 0);
            check("rst_ready",     bus.req_ready, 0);
            check("rst_w_en",      bus.fifo_w_en, 0);
            check("rst_d_in",      bus.fifo_d_in, 0);
            holder    = -1;
            last_srv  = N - 1;
            words     = 0;
            prev_gvld = 1'b0;
            exp_q.delete();
        end else begin
            if (holder >= 0) begin
                e_d = bus.req_data[holder*DW +: DW];
                if (!bus.fifo_full) begin
                    e_ready[holder] = 1'b1;
                    e_wen           = bus.req_valid[holder];
                end
            end
            check("grant_vld", bus.grant_vld, holder >= 0);
            if (holder >= 0) check("grant_id", bus.grant_id, holder);
            check("state_dbg",  bus.state_dbg, holder >= 0);
            check("word_cnt",   bus.word_cnt,  words % (1 << CW));
            check("word_cnt4",  bus4.word_cnt, words % 16);
            check("req_ready",  bus.req_ready, e_ready);
            check("w_en",       bus.fifo_w_en, e_wen);
            check("d_in",       bus.fifo_d_in, e_d);
            check("w_en_full",  bus.fifo_w_en & bus.fifo_full, 0);
            check("ready_1hot", $countones(bus.req_ready) <= 1, 1);

            if (bus.grant_vld && !prev_gvld) begin
                glog.push_back(int'(bus.grant_id));
                gcyc.push_back(cyc);
            end
            prev_gvld = bus.grant_vld;

            if (e_wen) exp_q.push_back(e_d);
            if (bus.fifo_w_en) begin
                wcyc.push_back(cyc);
                if (exp_q.size() == 0) check("sb_extra_write", 1, 0);
                else check("sb_data", bus.fifo_d_in, exp_q.pop_front());
            end

            // advance the model to what the coming edge should do
            if (holder < 0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (last_srv + k) % N;
                    if (holder < 0 && bus.req_valid[idx]) begin
                        holder   = idx;
                        last_srv = idx;
                    end
                end
            end else if (e_wen) begin
                words++;
                if (bus.req_last[holder]) holder = -1;
            end
        end
    end

    // ---------------- drivers ----------------
    // Sends one packet on requester id. Optionally drops valid for gap_len
    // cycles before beat gap_at.
    task automatic send_packet(input int id, input int len, input int gap_at, input int gap_len);
        int   beat   = 0;
        int   budget = 300;
        bit   gapped = 0;
        logic fired;
        while (beat < len && budget > 0) begin
            if (beat == gap_at && !gapped) begin
                bus.req_valid[id] = 1'b0;
                repeat (gap_len) @(posedge w_clk);
                #1 gapped = 1;
            end
            bus.req_valid[id]          = 1'b1;
            bus.req_data[id*DW +: DW]  = DW'($urandom);
            bus.req_last[id]           = (beat == len - 1);
            @(negedge w_clk);
            fired = bus.req_ready[id];
            @(posedge w_clk);
            #1;
            if (fired) beat++;
            budget--;
        end
        if (beat < len) check("pkt_timeout", beat, len);
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int cnt;
        int budget;
        wrst          = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        do_reset();

        // single 3-beat packet on requester 0
        glog.delete(); gcyc.delete(); wcyc.delete();
        send_packet(0, 3, -1, 0);
        idle_cycles(2);
        check("t1_word_cnt",  bus.word_cnt, 3);
        check("t1_ngrants",   glog.size(), 1);
        if (glog.size() >= 1) check("t1_grant_id", glog[0], 0);
        check("t1_nwrites",   wcyc.size(), 3);
        if (wcyc.size() == 3 && gcyc.size() >= 1) begin
            check("t1_first_beat", wcyc[0], gcyc[0]);
            check("t1_back2back",  wcyc[2] - wcyc[0], 2);
        end

        // all four requesters continuously valid with single-beat packets
        do_reset();
        glog.delete(); gcyc.delete();
        fork
            begin send_packet(0, 1, -1, 0); send_packet(0, 1, -1, 0); end
            begin send_packet(1, 1, -1, 0); send_packet(1, 1, -1, 0); end
            begin send_packet(2, 1, -1, 0); send_packet(2, 1, -1, 0); end
            begin send_packet(3, 1, -1, 0); send_packet(3, 1, -1, 0); end
        join
        idle_cycles(2);
        check("t2_ngrants", glog.size(), 8);
        if (glog.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("t2_rr_order", glog[i], i % N);
            for (int i = 1; i < 5; i++) check("t2_spacing", gcyc[i] - gcyc[i-1], 2);
        end

        // FIFO full for 5 cycles after beat 2 of a 4-beat packet on requester 1
        w0 = int'(words);
        fork
            send_packet(1, 4, -1, 0);
            begin
                cnt    = 0;
                budget = 100;
                while (cnt < 2 && budget > 0) begin
                    @(negedge w_clk);
                    if (bus.fifo_w_en && bus.grant_id == 1) cnt++;
                    budget--;
                end
                if (cnt < 2) check("t3_timeout", cnt, 2);
                @(posedge w_clk);
                #1 bus.fifo_full = 1'b1;
                repeat (5) begin
                    @(negedge w_clk);
                    check("t3_stall_ready", bus.req_ready[1], 0);
                    check("t3_stall_w_en",  bus.fifo_w_en, 0);
                    @(posedge w_clk);
                    #1;
                end
                bus.fifo_full = 1'b0;
            end
        join
        idle_cycles(2);
        check("t3_words", bus.word_cnt, w0 + 4);

        // requester 2 drops valid mid-packet while requester 0 waits
        glog.delete(); gcyc.delete();
        fork
            send_packet(2, 4, 2, 3);
            begin idle_cycles(3); send_packet(0, 1, -1, 0); end
        join
        idle_cycles(2);
        check("t4_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            check("t4_first",  glog[0], 2);
            check("t4_second", glog[1], 0);
        end

        // asynchronous reset in the middle of a packet on requester 3
        bus.req_valid[3]         = 1'b1;
        bus.req_data[3*DW +: DW] = 16'hBEEF;
        bus.req_last[3]          = 1'b0;
        idle_cycles(3);
        #2 wrst = 1'b1;
        #1;
        check("t5_async_gvld", bus.grant_vld, 0);
        check("t5_async_gid",  bus.grant_id, 0);
        check("t5_async_wen",  bus.fifo_w_en, 0);
        check("t5_async_rdy",  bus.req_ready, 0);
        check("t5_async_din",  bus.fifo_d_in, 0);
        check("t5_async_cnt",  bus.word_cnt, 0);
        bus.req_valid = '0;
        @(posedge w_clk);
        #1 wrst = 1'b0;
        bus.req_valid = '1;
        bus.req_last  = '1;
        @(posedge w_clk);
        #1 bus.req_valid = 4'b0001;
        @(negedge w_clk);
        check("t5_regrant_vld", bus.grant_vld, 1);
        check("t5_regrant_id",  bus.grant_id, 0);
        @(posedge w_clk);
        #1 bus.req_valid = '0;
        bus.req_last = '0;
        idle_cycles(2);

        // random traffic, inputs redrawn every cycle
        repeat (1500) begin
            bus.req_valid = N'($urandom);
            bus.req_data  = (N*DW)'({$urandom, $urandom});
            for (int i = 0; i < N; i++) bus.req_last[i] = ($urandom_range(0, 2) == 0);
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            idle_cycles(1);
        end
        bus.fifo_full = 1'b0;
        bus.req_last  = '1;
        repeat (4) begin
            bus.req_valid = bus.grant_vld ? (N'(1) << bus.grant_id) : '0;
            idle_cycles(1);
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        idle_cycles(1);
        check("drain_idle", bus.grant_vld, 0);
        check("drain_sb_empty", exp_q.size(), 0);

        // 17 single-beat writes: the 4-bit counter wraps to 1
        do_reset();
        repeat (17) send_packet($urandom_range(0, N - 1), 1, -1, 0);
        idle_cycles(2);
        check("t6_cnt4_wrap", bus4.word_cnt, 1);
        check("t6_cnt16",     bus.word_cnt, 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
